// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ==== hazard_stall_ctrl : pipeline stall/flush sequencer for load-use, shared RAM, branch ====
// ==== rev 1.0 ================================================================================
module hazard_stall_ctrl #(
   parameter int REG_ADDR_W = 4,
   parameter int WAIT_MAX   = 15,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] id_reg1_addr_i,
   input  logic [REG_ADDR_W-1:0] id_reg2_addr_i,
   input  logic                  id_reg1_used_i,
   input  logic                  id_reg2_used_i,
   input  logic [REG_ADDR_W-1:0] ex_wb_addr_i,
   input  logic                  ex_reg_we_i,
   input  logic                  ex_is_load_i,
   input  logic                  ex_br_taken_i,
   input  logic                  mem_req_i,
   input  logic                  mem_ready_i,
   output logic                  pc_stall_o,
   output logic                  if_id_stall_o,
   output logic                  id_ex_stall_o,
   output logic                  ex_mem_stall_o,
   output logic                  if_id_flush_o,
   output logic                  id_ex_flush_o,
   output logic                  mem_wb_flush_o,
   output logic                  ram_sel_mem_o,
   output logic                  mem_timeout_o,
   output logic [CNT_W-1:0]      stall_cnt_o,
   output logic [CNT_W-1:0]      flush_cnt_o
);

   localparam int WCNT_W = $clog2(WAIT_MAX + 1);
   localparam logic [WCNT_W-1:0] C_WAIT_MAX = WCNT_W'(WAIT_MAX);

   typedef enum logic [0:0] {
      ST_RUN      = 1'b0,
      ST_MEM_WAIT = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              timeout_q, timeout_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
   logic              lu;

   assign lu = ex_is_load_i & ex_reg_we_i &
               ((id_reg1_used_i & (id_reg1_addr_i == ex_wb_addr_i)) |
                (id_reg2_used_i & (id_reg2_addr_i == ex_wb_addr_i)));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_RUN;
         wait_cnt_q  <= '0;
         timeout_q   <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         timeout_q   <= timeout_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      wait_cnt_d     = wait_cnt_q;
      timeout_d      = timeout_q;
      pc_stall_o     = 1'b0;
      if_id_stall_o  = 1'b0;
      id_ex_stall_o  = 1'b0;
      ex_mem_stall_o = 1'b0;
      if_id_flush_o  = 1'b0;
      id_ex_flush_o  = 1'b0;
      mem_wb_flush_o = 1'b0;
      ram_sel_mem_o  = 1'b0;

      case (state_q)
         ST_RUN: begin
            if (mem_req_i && !mem_ready_i) begin
               ram_sel_mem_o  = 1'b1;
               pc_stall_o     = 1'b1;
               if_id_stall_o  = 1'b1;
               id_ex_stall_o  = 1'b1;
               ex_mem_stall_o = 1'b1;
               mem_wb_flush_o = 1'b1;
               state_d        = ST_MEM_WAIT;
               wait_cnt_d     = WCNT_W'(1);
            end else if (mem_req_i) begin
               // Single-cycle data access steals this fetch slot; lu keeps the ID instr instead.
               ram_sel_mem_o = 1'b1;
               pc_stall_o    = 1'b1;
               if_id_flush_o = !lu;
               if_id_stall_o = lu;
               id_ex_flush_o = ex_br_taken_i | lu;
            end else if (ex_br_taken_i) begin
               if_id_flush_o = 1'b1;
               id_ex_flush_o = 1'b1;
            end else if (lu) begin
               pc_stall_o    = 1'b1;
               if_id_stall_o = 1'b1;
               id_ex_flush_o = 1'b1;
            end
         end
         ST_MEM_WAIT: begin
            ram_sel_mem_o = 1'b1;
            pc_stall_o    = 1'b1;
            if_id_stall_o = 1'b1;
            id_ex_stall_o = 1'b1;
            if (mem_ready_i) begin
               state_d = ST_RUN;
            end else begin
               ex_mem_stall_o = 1'b1;
               mem_wb_flush_o = 1'b1;
               // Counter parks at WAIT_MAX; one further unfinished cycle flags the timeout.
               if (wait_cnt_q >= C_WAIT_MAX) begin
                  timeout_d = 1'b1;
               end else begin
                  wait_cnt_d = wait_cnt_q + WCNT_W'(1);
               end
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (pc_stall_o && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (id_ex_flush_o && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   assign mem_timeout_o = timeout_q;
   assign stall_cnt_o   = stall_cnt_q;
   assign flush_cnt_o   = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ==== tb_hazard_stall_ctrl : directed bench for hazard_stall_ctrl (WAIT_MAX=4, CNT_W=4) ====
module tb_hazard_stall_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] id_reg1_addr, id_reg2_addr, ex_wb_addr;
   logic       id_reg1_used, id_reg2_used, ex_reg_we, ex_is_load, ex_br_taken;
   logic       mem_req, mem_ready;
   logic       pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
   logic       if_id_flush, id_ex_flush, mem_wb_flush, ram_sel_mem, mem_timeout;
   logic [3:0] stall_cnt, flush_cnt;
   logic [7:0] ctrl;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   hazard_stall_ctrl #(.REG_ADDR_W(4), .WAIT_MAX(4), .CNT_W(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .id_reg1_addr_i (id_reg1_addr),
      .id_reg2_addr_i (id_reg2_addr),
      .id_reg1_used_i (id_reg1_used),
      .id_reg2_used_i (id_reg2_used),
      .ex_wb_addr_i   (ex_wb_addr),
      .ex_reg_we_i    (ex_reg_we),
      .ex_is_load_i   (ex_is_load),
      .ex_br_taken_i  (ex_br_taken),
      .mem_req_i      (mem_req),
      .mem_ready_i    (mem_ready),
      .pc_stall_o     (pc_stall),
      .if_id_stall_o  (if_id_stall),
      .id_ex_stall_o  (id_ex_stall),
      .ex_mem_stall_o (ex_mem_stall),
      .if_id_flush_o  (if_id_flush),
      .id_ex_flush_o  (id_ex_flush),
      .mem_wb_flush_o (mem_wb_flush),
      .ram_sel_mem_o  (ram_sel_mem),
      .mem_timeout_o  (mem_timeout),
      .stall_cnt_o    (stall_cnt),
      .flush_cnt_o    (flush_cnt)
   );

   // {pc_st, ifid_st, idex_st, exmem_st, ifid_fl, idex_fl, memwb_fl, ram_sel}
   assign ctrl = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                  if_id_flush, id_ex_flush, mem_wb_flush, ram_sel_mem};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_reg1_addr = 4'd0; id_reg2_addr = 4'd0; ex_wb_addr = 4'd0;
      id_reg1_used = 1'b0; id_reg2_used = 1'b0;
      ex_reg_we = 1'b0; ex_is_load = 1'b0; ex_br_taken = 1'b0;
      mem_req = 1'b0; mem_ready = 1'b0;
   endtask

   task automatic set_lu(input logic [3:0] r1, input logic [3:0] r2, input logic [3:0] wb);
      id_reg1_addr = r1; id_reg2_addr = r2; ex_wb_addr = wb;
      id_reg1_used = 1'b1; id_reg2_used = 1'b1;
      ex_reg_we = 1'b1; ex_is_load = 1'b1;
   endtask

   initial begin
      idle();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
      check("reset_ctrl", 32'(ctrl), 32'h00);
      check("reset_stall_cnt", 32'(stall_cnt), 32'd0);
      check("reset_flush_cnt", 32'(flush_cnt), 32'd0);
      check("reset_timeout", 32'(mem_timeout), 32'd0);

      // LW R1 in EX, ADDU R2=R1+R3 in ID
      set_lu(4'd1, 4'd3, 4'd1);
      #1 check("lu_reg1", 32'(ctrl), 32'hC4);
      tick();
      ex_is_load = 1'b0;
      #1 check("lu_clears", 32'(ctrl), 32'h00);
      check("lu_stall_cnt", 32'(stall_cnt), 32'd1);
      check("lu_flush_cnt", 32'(flush_cnt), 32'd1);

      // operand 2 match at address 0 (not special)
      set_lu(4'd5, 4'd0, 4'd0);
      #1 check("lu_reg2_addr0", 32'(ctrl), 32'hC4);
      id_reg2_used = 1'b0;
      #1 check("lu_unused_operand", 32'(ctrl), 32'h00);
      id_reg2_used = 1'b1; ex_reg_we = 1'b0;
      #1 check("lu_no_we", 32'(ctrl), 32'h00);
      ex_reg_we = 1'b1;
      tick();
      idle();
      #1 check("lu2_stall_cnt", 32'(stall_cnt), 32'd2);

      // single-cycle MEM access in RUN
      mem_req = 1'b1; mem_ready = 1'b1;
      #1 check("mem_ready_run", 32'(ctrl), 32'h89);
      tick();
      idle();
      #1 check("mem_ready_stays_run", 32'(ctrl), 32'h00);
      check("mem_ready_stall_cnt", 32'(stall_cnt), 32'd3);
      check("mem_ready_flush_cnt", 32'(flush_cnt), 32'd2);

      // branch beats load-use
      set_lu(4'd2, 4'd7, 4'd2);
      ex_br_taken = 1'b1;
      #1 check("branch_wins", 32'(ctrl), 32'h0C);
      tick();
      idle();
      #1 check("branch_flush_cnt", 32'(flush_cnt), 32'd3);
      check("branch_stall_cnt", 32'(stall_cnt), 32'd3);

      // MEM access completing together with a load-use
      set_lu(4'd4, 4'd6, 4'd6);
      mem_req = 1'b1; mem_ready = 1'b1;
      #1 check("mem_ready_lu", 32'(ctrl), 32'hC5);
      tick();
      idle();

      // three wait cycles, then ready
      mem_req = 1'b1; mem_ready = 1'b0;
      #1 check("wait_c1", 32'(ctrl), 32'hF3);
      tick();
      ex_br_taken = 1'b1;
      #1 check("wait_c2_branch_ignored", 32'(ctrl), 32'hF3);
      tick();
      #1 check("wait_c3", 32'(ctrl), 32'hF3);
      tick();
      mem_ready = 1'b1;
      #1 check("wait_retire", 32'(ctrl), 32'hE1);
      tick();
      idle();
      #1 check("wait_back_run", 32'(ctrl), 32'h00);
      check("wait_stall_cnt", 32'(stall_cnt), 32'd8);
      check("wait_flush_cnt", 32'(flush_cnt), 32'd4);
      check("wait_no_timeout", 32'(mem_timeout), 32'd0);

      // timeout with WAIT_MAX=4
      mem_req = 1'b1; mem_ready = 1'b0;
      tick();
      tick();
      tick();
      tick();
      #1 check("timeout_not_yet", 32'(mem_timeout), 32'd0);
      tick();
      #1 check("timeout_set", 32'(mem_timeout), 32'd1);
      check("timeout_stall_cnt", 32'(stall_cnt), 32'd13);
      mem_req = 1'b0;
      #1 check("wait_holds_without_req", 32'(ctrl), 32'hF3);
      tick();
      #1 check("timeout_sticky", 32'(mem_timeout), 32'd1);
      check("timeout_stall_cnt2", 32'(stall_cnt), 32'd14);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1 check("rst_timeout", 32'(mem_timeout), 32'd0);
      check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      check("rst_ctrl_run", 32'(ctrl), 32'h00);

      // saturation of 4-bit counters
      set_lu(4'd3, 4'd9, 4'd3);
      for (int i = 0; i < 20; i++) tick();
      check("stall_cnt_sat", 32'(stall_cnt), 32'd15);
      check("flush_cnt_sat", 32'(flush_cnt), 32'd15);
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
